// File: rtl/mcpu_mem_pkg.sv
// Shared LTC request definitions for the MCPU memory arbiter.
// Holds the opcode encodings, field widths, the packed request record
// and the helper that classifies read-type opcodes.
package mcpu_mem_pkg;

    localparam int LTC_OPC_W  = 3;
    localparam int LTC_ADDR_W = 27;
    localparam int LTC_DATA_W = 256;
    localparam int LTC_WBE_W  = 32;

    localparam logic [2:0] LTC_OPC_READ         = 3'd0;
    localparam logic [2:0] LTC_OPC_READTHROUGH  = 3'd1;
    localparam logic [2:0] LTC_OPC_WRITE        = 3'd2;
    localparam logic [2:0] LTC_OPC_WRITETHROUGH = 3'd3;
    localparam logic [2:0] LTC_OPC_PREFETCH     = 3'd4;

    typedef struct packed {
        logic [LTC_OPC_W-1:0]  opcode;
        logic [LTC_ADDR_W-1:0] addr;
        logic [LTC_DATA_W-1:0] wdata;
        logic [LTC_WBE_W-1:0]  wbe;
    } ltc_req_t;

    // Only these two opcodes produce read data that must be routed back.
    function automatic logic ltc_opc_is_read(input logic [2:0] opc);
        case (opc)
            LTC_OPC_READ,
            LTC_OPC_READTHROUGH: ltc_opc_is_read = 1'b1;
            default:             ltc_opc_is_read = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mcpu_mem_arb_rr_pick.sv
// Rotating priority encoder: finds the first valid client after cur,
// wrapping modulo CLIENTS. Returns cur when no other client is valid.
module mcpu_mem_arb_rr_pick #(
    parameter int CLIENTS      = 4,
    parameter int CLIENTS_BITS = 2
)(
    input  logic [CLIENTS-1:0]      valid,
    input  logic [CLIENTS_BITS-1:0] cur,
    output logic [CLIENTS_BITS-1:0] next,
    output logic                    any_other
);

    logic [CLIENTS_BITS-1:0] idx_s;

    // Scan from farthest to nearest so the nearest valid client wins.
    always_comb begin
        next      = cur;
        any_other = 1'b0;
        idx_s     = cur;
        for (int k = CLIENTS - 1; k >= 1; k--) begin
            idx_s     = CLIENTS_BITS'((int'(cur) + k) % CLIENTS);
            next      = valid[idx_s] ? idx_s : next;
            any_other = any_other | valid[idx_s];
        end
    end

endmodule

// File: rtl/mcpu_mem_fifo.sv
// Small synchronous FIFO used to hold the owner tag of each outstanding read.
// Push and pop in the same cycle are allowed at both full and empty:
// at full the pop frees the slot the push uses; at empty nothing is popped.
module mcpu_mem_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 2
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == (PTR_W+1)'(DEPTH));
    assign empty     = (count_r == {(PTR_W+1){1'b0}});
    assign push_ok_s = push & (~full | pop);
    assign pop_ok_s  = pop & ~empty;
    assign pop_data  = mem_r[rd_ptr_r];

    // Storage array: data only, no reset needed since count gates validity.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointers and occupancy; depth is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W+1){1'b0}};
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            else           wr_ptr_r <= wr_ptr_r;
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            else           rd_ptr_r <= rd_ptr_r;
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/mcpu_mem_arb_wrr.sv
// Weighted round-robin arbiter from MCPU memory clients to the LTC port.
// Each owner keeps the port for weight[owner] accepts (0 behaves as 1),
// then ownership moves to the next valid client with no idle cycle.
// A tag FIFO remembers the owner of every outstanding read so returning
// data can be steered back; a return with no outstanding read sets arb_err.
// Optional macro MCPU_MEM_ARB_PRIO_EN makes client 0 urgent: it wins every
// rotation it is valid for, and shortens any other owner's turn.
module mcpu_mem_arb_wrr
    import mcpu_mem_pkg::*;
#(
    parameter int CLIENTS         = 4,
    parameter int CLIENTS_BITS    = 2,
    parameter int CREDITS_BITS    = 4,
    parameter int CREDITS_DEFAULT = 1,
    parameter int RDFIFO_DEPTH    = 8
)(
    input  logic                             clkrst_mem_clk,
    input  logic                             clkrst_mem_rst_n,
    output logic                             arb2ltc_valid,
    output logic [2:0]                       arb2ltc_opcode,
    output logic [31:5]                      arb2ltc_addr,
    output logic [LTC_DATA_W-1:0]            arb2ltc_wdata,
    output logic [LTC_WBE_W-1:0]             arb2ltc_wbe,
    input  logic                             arb2ltc_stall,
    input  logic [LTC_DATA_W-1:0]            arb2ltc_rdata,
    input  logic                             arb2ltc_rvalid,
    input  logic [CLIENTS-1:0]               cli2arb_valid,
    input  logic [CLIENTS*LTC_OPC_W-1:0]     cli2arb_opcode,
    input  logic [CLIENTS*LTC_ADDR_W-1:0]    cli2arb_addr,
    input  logic [CLIENTS*LTC_DATA_W-1:0]    cli2arb_wdata,
    input  logic [CLIENTS*LTC_WBE_W-1:0]     cli2arb_wbe,
    output logic [CLIENTS-1:0]               cli2arb_stall,
    output logic [LTC_DATA_W-1:0]            cli2arb_rdata,
    output logic [CLIENTS-1:0]               cli2arb_rvalid,
    input  logic                             csr_wr,
    input  logic [CLIENTS_BITS-1:0]          csr_sel,
    input  logic [CREDITS_BITS-1:0]          csr_wdata,
    output logic                             arb_err
);

    localparam logic [CREDITS_BITS-1:0] CREDITS_ONE   = CREDITS_BITS'(1);
    localparam logic [CREDITS_BITS-1:0] CREDITS_RESET =
        (CREDITS_DEFAULT == 0) ? CREDITS_BITS'(1) : CREDITS_BITS'(CREDITS_DEFAULT);
    localparam logic [CLIENTS-1:0]      ONE_HOT0      = CLIENTS'(1);

    // A weight of zero still grants one access per turn.
    function automatic logic [CREDITS_BITS-1:0] floor_one(input logic [CREDITS_BITS-1:0] w);
        floor_one = (w == {CREDITS_BITS{1'b0}}) ? CREDITS_ONE : w;
    endfunction

    logic [CLIENTS_BITS-1:0] cur_r;
    logic [CREDITS_BITS-1:0] credits_left_r;
    logic [CREDITS_BITS-1:0] weight_r [CLIENTS];
    logic [CLIENTS-1:0]      rvalid_r;
    logic [LTC_DATA_W-1:0]   rdata_r;
    logic                    arb_err_r;

    ltc_req_t                req_arr_s [CLIENTS];
    ltc_req_t                sel_req_s;
    logic                    sel_valid_s;
    logic                    sel_is_read_s;
    logic                    rd_wait_s;
    logic                    accept_s;
    logic                    urgent_s;
    logic                    turn_end_s;
    logic                    rotate_s;
    logic [CLIENTS_BITS-1:0] pick_next_s;
    logic                    pick_any_s;
    logic [CLIENTS_BITS-1:0] next_owner_s;
    logic [CREDITS_BITS-1:0] next_weight_s;
    logic                    fifo_full_s;
    logic                    fifo_empty_s;
    logic                    fifo_pop_s;
    logic                    underflow_s;
    logic [CLIENTS_BITS-1:0] fifo_tag_s;

    for (genvar g = 0; g < CLIENTS; g++) begin : g_client
        assign req_arr_s[g] = {cli2arb_opcode[g*LTC_OPC_W +: LTC_OPC_W],
                               cli2arb_addr[g*LTC_ADDR_W +: LTC_ADDR_W],
                               cli2arb_wdata[g*LTC_DATA_W +: LTC_DATA_W],
                               cli2arb_wbe[g*LTC_WBE_W +: LTC_WBE_W]};
        assign cli2arb_stall[g] = cli2arb_valid[g] &
                                  ((cur_r != CLIENTS_BITS'(g)) | arb2ltc_stall | rd_wait_s);
    end

    assign sel_req_s     = req_arr_s[cur_r];
    assign sel_valid_s   = cli2arb_valid[cur_r];
    assign sel_is_read_s = ltc_opc_is_read(sel_req_s.opcode);
    assign rd_wait_s     = sel_valid_s & sel_is_read_s & fifo_full_s;

    assign arb2ltc_valid  = sel_valid_s & ~rd_wait_s;
    assign arb2ltc_opcode = sel_req_s.opcode;
    assign arb2ltc_addr   = sel_req_s.addr;
    assign arb2ltc_wdata  = sel_req_s.wdata;
    assign arb2ltc_wbe    = sel_req_s.wbe;
    assign accept_s       = arb2ltc_valid & ~arb2ltc_stall;

    mcpu_mem_arb_rr_pick #(
        .CLIENTS      (CLIENTS),
        .CLIENTS_BITS (CLIENTS_BITS)
    ) u_pick (
        .valid     (cli2arb_valid),
        .cur       (cur_r),
        .next      (pick_next_s),
        .any_other (pick_any_s)
    );

`ifdef MCPU_MEM_ARB_PRIO_EN
    assign urgent_s     = cli2arb_valid[0] & (cur_r != {CLIENTS_BITS{1'b0}});
    assign next_owner_s = cli2arb_valid[0] ? {CLIENTS_BITS{1'b0}}
                                           : (pick_any_s ? pick_next_s : cur_r);
`else
    assign urgent_s     = 1'b0;
    assign next_owner_s = pick_any_s ? pick_next_s : cur_r;
`endif

    // An owner that is idle while the port is free gives way at once; an
    // active owner gives way after the accept that uses its last credit.
    assign turn_end_s    = (credits_left_r == CREDITS_ONE) | urgent_s;
    assign rotate_s      = (accept_s & turn_end_s) | (~sel_valid_s & ~arb2ltc_stall);
    // A weight written in the same cycle as its owner's reload is used immediately.
    assign next_weight_s = (csr_wr && (csr_sel == next_owner_s)) ? csr_wdata
                                                                 : weight_r[next_owner_s];

    // Owner pointer and remaining credits; both hold while the LTC stalls.
    always_ff @(posedge clkrst_mem_clk or negedge clkrst_mem_rst_n) begin
        if (!clkrst_mem_rst_n) begin
            cur_r          <= {CLIENTS_BITS{1'b0}};
            credits_left_r <= CREDITS_RESET;
        end else if (rotate_s) begin
            cur_r          <= next_owner_s;
            credits_left_r <= floor_one(next_weight_s);
        end else if (accept_s) begin
            cur_r          <= cur_r;
            credits_left_r <= credits_left_r - CREDITS_ONE;
        end else begin
            cur_r          <= cur_r;
            credits_left_r <= credits_left_r;
        end
    end

    // Programmable per-client weights.
    always_ff @(posedge clkrst_mem_clk or negedge clkrst_mem_rst_n) begin
        if (!clkrst_mem_rst_n) begin
            for (int i = 0; i < CLIENTS; i++) begin
                weight_r[i] <= CREDITS_BITS'(CREDITS_DEFAULT);
            end
        end else if (csr_wr) begin
            weight_r[csr_sel] <= csr_wdata;
        end else begin
            weight_r[csr_sel] <= weight_r[csr_sel];
        end
    end

    assign fifo_pop_s  = arb2ltc_rvalid & ~fifo_empty_s;
    assign underflow_s = arb2ltc_rvalid & fifo_empty_s;

    mcpu_mem_fifo #(
        .DEPTH (RDFIFO_DEPTH),
        .WIDTH (CLIENTS_BITS)
    ) u_tag_fifo (
        .clk       (clkrst_mem_clk),
        .rst_n     (clkrst_mem_rst_n),
        .push      (accept_s & sel_is_read_s),
        .push_data (cur_r),
        .pop       (fifo_pop_s),
        .pop_data  (fifo_tag_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Read return: data and owner tag are registered together, one pulse per beat.
    always_ff @(posedge clkrst_mem_clk or negedge clkrst_mem_rst_n) begin
        if (!clkrst_mem_rst_n) begin
            rvalid_r <= {CLIENTS{1'b0}};
            rdata_r  <= {LTC_DATA_W{1'b0}};
        end else if (fifo_pop_s) begin
            rvalid_r <= ONE_HOT0 << fifo_tag_s;
            rdata_r  <= arb2ltc_rdata;
        end else begin
            rvalid_r <= {CLIENTS{1'b0}};
            rdata_r  <= rdata_r;
        end
    end

    // Sticky flag for read data arriving with no outstanding read.
    always_ff @(posedge clkrst_mem_clk or negedge clkrst_mem_rst_n) begin
        if (!clkrst_mem_rst_n) begin
            arb_err_r <= 1'b0;
        end else if (underflow_s) begin
            arb_err_r <= 1'b1;
        end else begin
            arb_err_r <= arb_err_r;
        end
    end

    assign cli2arb_rvalid = rvalid_r;
    assign cli2arb_rdata  = rdata_r;
    assign arb_err        = arb_err_r;

endmodule

// File: tb/tb_mcpu_mem_arb_wrr.sv
// Scoreboard bench for mcpu_mem_arb_wrr (4 clients, 2-deep read tag FIFO).
// Stimulus pushes the expected grant owners and read returns into queues;
// a negedge monitor pops and compares whenever the DUT presents a grant
// or a read return.
module tb_mcpu_mem_arb_wrr;
    import mcpu_mem_pkg::*;

    localparam int N = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  arb2ltc_valid;
    logic [2:0]            arb2ltc_opcode;
    logic [31:5]           arb2ltc_addr;
    logic [255:0]          arb2ltc_wdata;
    logic [31:0]           arb2ltc_wbe;
    logic                  arb2ltc_stall;
    logic [255:0]          arb2ltc_rdata;
    logic                  arb2ltc_rvalid;
    logic [N-1:0]          cli2arb_valid;
    logic [N*3-1:0]        cli2arb_opcode;
    logic [N*27-1:0]       cli2arb_addr;
    logic [N*256-1:0]      cli2arb_wdata;
    logic [N*32-1:0]       cli2arb_wbe;
    logic [N-1:0]          cli2arb_stall;
    logic [255:0]          cli2arb_rdata;
    logic [N-1:0]          cli2arb_rvalid;
    logic                  csr_wr;
    logic [1:0]            csr_sel;
    logic [3:0]            csr_wdata;
    logic                  arb_err;

    logic [2:0]            cli_op [N];
    int                    errors = 0;
    int                    checks = 0;
    bit                    mon_en = 1'b0;
    int                    exp_q [$];
    logic [259:0]          rd_q [$];
    int                    mon_id;
    logic [259:0]          mon_rd;
    int                    cyc;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_cli
        assign cli2arb_opcode[g*3 +: 3]    = cli_op[g];
        assign cli2arb_addr[g*27 +: 27]    = 27'h100 + 27'(g);
        assign cli2arb_wdata[g*256 +: 256] = {8{32'hC0DE_0000 + 32'(g)}};
        assign cli2arb_wbe[g*32 +: 32]     = 32'h0000_000F << (4 * g);
    end

    mcpu_mem_arb_wrr #(
        .CLIENTS         (4),
        .CLIENTS_BITS    (2),
        .CREDITS_BITS    (4),
        .CREDITS_DEFAULT (1),
        .RDFIFO_DEPTH    (2)
    ) dut (
        .clkrst_mem_clk   (clk),
        .clkrst_mem_rst_n (rst_n),
        .arb2ltc_valid    (arb2ltc_valid),
        .arb2ltc_opcode   (arb2ltc_opcode),
        .arb2ltc_addr     (arb2ltc_addr),
        .arb2ltc_wdata    (arb2ltc_wdata),
        .arb2ltc_wbe      (arb2ltc_wbe),
        .arb2ltc_stall    (arb2ltc_stall),
        .arb2ltc_rdata    (arb2ltc_rdata),
        .arb2ltc_rvalid   (arb2ltc_rvalid),
        .cli2arb_valid    (cli2arb_valid),
        .cli2arb_opcode   (cli2arb_opcode),
        .cli2arb_addr     (cli2arb_addr),
        .cli2arb_wdata    (cli2arb_wdata),
        .cli2arb_wbe      (cli2arb_wbe),
        .cli2arb_stall    (cli2arb_stall),
        .cli2arb_rdata    (cli2arb_rdata),
        .cli2arb_rvalid   (cli2arb_rvalid),
        .csr_wr           (csr_wr),
        .csr_sel          (csr_sel),
        .csr_wdata        (csr_wdata),
        .arb_err          (arb_err)
    );

    task automatic check(input string name, input logic [287:0] act, input logic [287:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Request fields client id should present when granted.
    function automatic logic [61:0] exp_req(input int id);
        exp_req = {cli_op[id], 27'h100 + 27'(id), 32'h0000_000F << (4 * id)};
    endfunction

    // Monitor: compare every presented grant and every read return.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (arb2ltc_valid && !arb2ltc_stall) begin
                if (exp_q.size() == 0) begin
                    check("grant_unexpected", 288'({arb2ltc_opcode, arb2ltc_addr, arb2ltc_wbe}), 288'(0));
                end else begin
                    mon_id = exp_q.pop_front();
                    check($sformatf("grant_c%0d", mon_id),
                          288'({arb2ltc_opcode, arb2ltc_addr, arb2ltc_wbe}), 288'(exp_req(mon_id)));
                end
            end
            if (cli2arb_rvalid != 4'b0000) begin
                if (rd_q.size() == 0) begin
                    check("rvalid_unexpected", 288'(cli2arb_rvalid), 288'(0));
                end else begin
                    mon_rd = rd_q.pop_front();
                    check("rd_return", 288'({cli2arb_rvalid, cli2arb_rdata}), 288'(mon_rd));
                end
            end
        end
    end

    task automatic do_reset();
        rst_n          = 1'b0;
        cli2arb_valid  = 4'b0000;
        arb2ltc_stall  = 1'b0;
        arb2ltc_rvalid = 1'b0;
        arb2ltc_rdata  = 256'h0;
        csr_wr         = 1'b0;
        csr_sel        = 2'd0;
        csr_wdata      = 4'd0;
        for (int i = 0; i < N; i++) cli_op[i] = LTC_OPC_WRITE;
        exp_q.delete();
        rd_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic csr_write(input logic [1:0] sel, input logic [3:0] w);
        csr_wr    = 1'b1;
        csr_sel   = sel;
        csr_wdata = w;
        @(posedge clk);
        #1 csr_wr = 1'b0;
    endtask

    // Wait until both queues are drained, bounded; returns cycles spent.
    task automatic drain(output int n);
        n = 0;
        while ((exp_q.size() != 0 || rd_q.size() != 0) && n < 60) begin
            @(posedge clk);
            #1 n++;
        end
        if (exp_q.size() != 0 || rd_q.size() != 0) begin
            check("drain_timeout", 288'(exp_q.size() + rd_q.size()), 288'(0));
            exp_q.delete();
            rd_q.delete();
        end
    endtask

    task automatic issue(input int id);
        cli2arb_valid = 4'b0001 << id;
        exp_q.push_back(id);
        drain(cyc);
        cli2arb_valid = 4'b0000;
    endtask

    initial begin
        // Reset state and combinational request path.
        do_reset();
        check("rst_err", 288'(arb_err), 288'(0));
        check("rst_rvalid", 288'(cli2arb_rvalid), 288'(0));
        check("rst_rdata", 288'(cli2arb_rdata), 288'(0));
        check("rst_valid_idle", 288'(arb2ltc_valid), 288'(0));
        cli2arb_valid = 4'b0001;
        #1;
        check("rst_valid_follow", 288'(arb2ltc_valid), 288'(1));
        check("rst_stall_c0", 288'(cli2arb_stall), 288'(0));
        cli2arb_valid = 4'b0000;
        mon_en = 1'b1;

        // Weights {3,1,1,1}, all valid: 0,0,0,1,2,3 repeating, no bubble.
        do_reset();
        csr_write(2'd0, 4'd3);
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
            exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
        end
        cli2arb_valid = 4'b1111;
        drain(cyc);
        cli2arb_valid = 4'b0000;
        check("wrr_cycles", 288'(cyc), 288'(12));

        // Idle skip: only clients 1 and 3 valid.
        do_reset();
        for (int r = 0; r < 3; r++) begin
            exp_q.push_back(1); exp_q.push_back(3);
        end
        cli2arb_valid = 4'b1010;
        drain(cyc);
        cli2arb_valid = 4'b0000;
        check("skip_cycles", 288'(cyc), 288'(7));

        // Stall hold mid-turn: owner 0 with weight 3, client 1 waiting.
        do_reset();
        csr_write(2'd0, 4'd3);
        exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(1);
        cli2arb_valid = 4'b0011;
        #1;
        check("pre_stall_vec", 288'(cli2arb_stall), 288'(4'b0010));
        @(posedge clk);
        #1 arb2ltc_stall = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("stall_vec", 288'(cli2arb_stall), 288'(4'b0011));
            check("stall_addr", 288'({arb2ltc_valid, arb2ltc_addr}), 288'({1'b1, 27'h100}));
            @(posedge clk);
            #1;
        end
        check("stall_no_grant", 288'(exp_q.size()), 288'(3));
        arb2ltc_stall = 1'b0;
        drain(cyc);
        cli2arb_valid = 4'b0000;

        // Read routing through a full 2-deep tag FIFO.
        do_reset();
        cli_op[1] = LTC_OPC_READ;
        cli_op[2] = LTC_OPC_READTHROUGH;
        cli_op[3] = LTC_OPC_READ;
        issue(2);
        issue(1);
        cli2arb_valid = 4'b1000;
        exp_q.push_back(3);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check("full_valid", 288'(arb2ltc_valid), 288'(0));
            check("full_stall", 288'(cli2arb_stall), 288'(4'b1000));
        end
        check("full_no_grant", 288'(exp_q.size()), 288'(1));
        arb2ltc_rvalid = 1'b1;
        arb2ltc_rdata  = {8{32'hAAAA_0001}};
        rd_q.push_back({4'b0100, {8{32'hAAAA_0001}}});
        #1;
        check("rv_latency", 288'(cli2arb_rvalid), 288'(0));
        @(posedge clk);
        #1 arb2ltc_rvalid = 1'b0;
        drain(cyc);
        cli2arb_valid  = 4'b0000;
        arb2ltc_rvalid = 1'b1;
        arb2ltc_rdata  = {8{32'hBBBB_0002}};
        rd_q.push_back({4'b0010, {8{32'hBBBB_0002}}});
        @(posedge clk);
        #1 arb2ltc_rdata = {8{32'hCCCC_0003}};
        rd_q.push_back({4'b1000, {8{32'hCCCC_0003}}});
        @(posedge clk);
        #1 arb2ltc_rvalid = 1'b0;
        drain(cyc);
        check("rd_fifo_err", 288'(arb_err), 288'(0));

        // CSR write mid-turn: current turn grants 4, next turn grants 1.
        do_reset();
        csr_write(2'd0, 4'd4);
        exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
        exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(1);
        cli2arb_valid = 4'b0011;
        @(posedge clk);
        #1 csr_wr = 1'b1; csr_sel = 2'd0; csr_wdata = 4'd1;
        @(posedge clk);
        #1 csr_wr = 1'b0;
        drain(cyc);
        cli2arb_valid = 4'b0000;

        // Underflow: return with no outstanding read.
        check("pre_underflow_err", 288'(arb_err), 288'(0));
        arb2ltc_rvalid = 1'b1;
        arb2ltc_rdata  = {8{32'hDEAD_0004}};
        @(posedge clk);
        #1 arb2ltc_rvalid = 1'b0;
        check("underflow_err", 288'(arb_err), 288'(1));
        check("underflow_rvalid", 288'(cli2arb_rvalid), 288'(0));
        repeat (2) @(posedge clk);
        #1;
        check("err_sticky", 288'(arb_err), 288'(1));
        do_reset();
        check("err_reset", 288'(arb_err), 288'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
